// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store initiator for a word-addressed data memory
module mem_access_unit #(
    parameter int N     = 32,
    parameter int ADR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    input  logic             we,
    input  logic [2:0]       funct3,
    input  logic [31:0]      addr,
    input  logic [N-1:0]     wdata,
    output logic             ready,
    output logic             done,
    output logic [N-1:0]     rdata,
    output logic             err,
    output logic [ADR_W-1:0] mem_adr,
    output logic             mem_write_en,
    output logic [N-1:0]     mem_data_in,
    input  logic [N-1:0]     mem_data_out
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LO   = 2'd1;
    localparam logic [1:0] S_HI   = 2'd2;

    logic [1:0]       state;
    logic             we_q;
    logic [2:0]       f3_q;
    logic [ADR_W-1:0] a_q;
    logic [1:0]       o_q;
    logic [N-1:0]     wdata_q;
    logic [N-1:0]     byte_buf;

    logic [2:0]       size_n;
    logic             split;
    logic             legal;
    logic [2:0]       lane_k;
    logic [N-1:0]     merged;
    logic [N-1:0]     buf_next;
    logic [N-1:0]     load_ext;

    wire unused_addr_bits = ^addr[31:ADR_W+2];

    // Access size in bytes and whether the access spills into the next word
    always_comb begin
        size_n = 3'd4;
        if (f3_q[1:0] == 2'b00)
            size_n = 3'd1;
        else if (f3_q[1:0] == 2'b01)
            size_n = 3'd2;
        split = ({1'b0, o_q} + size_n) > 3'd4;
    end

    // Legal funct3 encodings for the incoming request
    always_comb begin
        if (we)
            legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        else
            legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                    (funct3 == 3'b100) || (funct3 == 3'b101);
    end

    // Lane j of the current word holds access byte k = j + 4*hi - o; the 3-bit
    // wrap makes lanes below the offset land on k >= 5, which fails k < n.
    always_comb begin
        merged   = mem_data_out;
        buf_next = byte_buf;
        lane_k   = 3'd0;
        for (int j = 0; j < 4; j++) begin
            lane_k = 3'(j) + ((state == S_HI) ? 3'd4 : 3'd0) - {1'b0, o_q};
            if (lane_k < size_n) begin
                merged[8*j +: 8]              = wdata_q[8*lane_k[1:0] +: 8];
                buf_next[8*lane_k[1:0] +: 8]  = mem_data_out[8*j +: 8];
            end
        end
    end

    // Sign or zero extension of the assembled load bytes
    always_comb begin
        case (f3_q)
            3'b000:  load_ext = {{24{buf_next[7]}}, buf_next[7:0]};
            3'b001:  load_ext = {{16{buf_next[15]}}, buf_next[15:0]};
            3'b100:  load_ext = {24'd0, buf_next[7:0]};
            3'b101:  load_ext = {16'd0, buf_next[15:0]};
            default: load_ext = buf_next;
        endcase
    end

    // Memory port drive; everything is quiet while idle
    always_comb begin
        ready        = (state == S_IDLE);
        mem_adr      = '0;
        mem_write_en = 1'b0;
        mem_data_in  = '0;
        if (state == S_LO)
            mem_adr = a_q;
        else if (state == S_HI)
            mem_adr = a_q + 1'b1;
        if (state != S_IDLE && we_q) begin
            mem_write_en = 1'b1;
            mem_data_in  = merged;
        end
    end

    // Access sequencer: accept, walk LO/HI, then report completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            we_q     <= 1'b0;
            f3_q     <= 3'd0;
            a_q      <= '0;
            o_q      <= 2'd0;
            wdata_q  <= '0;
            byte_buf <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            rdata    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        f3_q    <= funct3;
                        a_q     <= addr[ADR_W+1:2];
                        o_q     <= addr[1:0];
                        wdata_q <= wdata;
                        if (legal) begin
                            state <= S_LO;
                        end else begin
                            done  <= 1'b1;
                            err   <= 1'b1;
                            rdata <= '0;
                        end
                    end
                end
                S_LO, S_HI: begin
                    if (!we_q)
                        byte_buf <= buf_next;
                    if (state == S_LO && split) begin
                        state <= S_HI;
                    end else begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                        err   <= 1'b0;
                        if (!we_q)
                            rdata <= load_ext;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Initiator side of the word-addressed data memory port: sits in the MEM stage of the pipeline and turns RISC-V load/store requests (byte address, LB/LH/LW/LBU/LHU/SB/SH/SW) into word accesses on the memory's `adr`/`write_en`/`data_in`/`data_out` interface. Handles byte-lane selection, sign/zero extension, read-modify-write for sub-word stores, and splits word-boundary-crossing accesses into two memory cycles. Stalls the pipeline via `ready` while an access is in flight.

## Interface
- `N`, 32, data width; fixed at 32, the lane logic assumes 4 bytes.
- `ADR_W`, 8, memory word-address width.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  1  access request; sampled only when `ready`=1.
- `we`  in  1  1 = store, 0 = load.
- `funct3`  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU. Stores use 000/001/010.
- `addr`  in  32  byte address; only `addr[ADR_W+1:0]` is used.
- `wdata`  in  N  store data; low bytes are used for B/H.
- `ready`  out  1  1 in IDLE only; the pipeline stalls on `~ready`.
- `done`  out  1  one-cycle pulse when an access completes.
- `rdata`  out  N  load result; held until the next `done`.
- `err`  out  1  qualified by `done`; illegal `funct3` for the given `we`.
- `mem_adr`  out  ADR_W  word address to the memory.
- `mem_write_en`  out  1  memory write strobe.
- `mem_data_in`  out  N  write word to the memory.
- `mem_data_out`  in  N  memory read word; combinational from `mem_adr`.

## Operation
- Request fields are latched on acceptance.
  - Word index: `A = addr[ADR_W+1:2]`.
  - Byte offset: `o = addr[1:0]`.
  - Size: `n` = 1, 2 or 4 bytes.
- Lanes are little-endian. Byte k of the access (k = 0..n-1) sits at byte address `addr+k`.
  - When `o+k < 4`: lane `o+k` of word A.
  - Otherwise: lane `o+k-4` of word `A+1`.
  - `A+1` wraps modulo 2^ADR_W (255 → 0).
- The access is a split access iff `o+n > 4`.
- State machine:
  - IDLE (reset state):
    - `ready`=1.
    - On `req`: latch all request fields.
    - Legal `funct3` → go to LO.
    - Illegal `funct3` (loads 011/110/111; stores anything other than 000/001/010) → stay in IDLE. Next cycle: `done`=1, `err`=1, `rdata`=0. No memory access is made.
  - LO:
    - `mem_adr`=A.
    - Store: `mem_data_in` = `mem_data_out` with the lanes in word A replaced by their `wdata` bytes; `mem_write_en`=1.
    - Load: copy the lanes in word A into an internal byte buffer.
    - Go to HI if split, else to IDLE with `done` set.
  - HI:
    - `mem_adr`=A+1. Same merge/capture for the remaining bytes.
    - Go to IDLE with `done` set.
- On `done` for a load, `rdata` gets the assembled bytes, extended to N bits:
  - B/H: sign-extended.
  - BU/HU/W: zero-extended.
- On `done` for a store, `rdata` is unchanged.
- `mem_adr`, `mem_write_en`, `mem_data_in` are combinational from state and the latched fields. All three are 0 in IDLE.

## Timing
- Reset values: `ready`=1, `done`=0, `rdata`=0, `err`=0, `mem_write_en`=0, `mem_adr`=0, `mem_data_in`=0. State = IDLE.
- Cycle numbering: acceptance edge = end of cycle 0.
  - Non-split: LO in cycle 1; `done`=1 in cycle 2.
  - Split: LO in cycle 1, HI in cycle 2; `done` in cycle 3.
  - `ready`=0 for 1 or 2 cycles respectively.
- Back-to-back: `ready`=1 in the `done` cycle, so a new `req` is accepted in that same cycle.
- `req` while `ready`=0 is ignored; the requester holds the request until `ready`=1.
- Each memory write takes effect at the end of its LO/HI cycle. A load issued in the `done` cycle of a store sees the new data.
- Async reset mid-access:
  - All outputs return to their reset values immediately, including `mem_write_en`=0.
  - A split store interrupted in HI leaves word A written and word A+1 untouched.
  - No `done` is produced.

## Test plan
- Reset check: drive `rst_n`=0 → `ready`=1, `done`=0, `rdata`=0, `mem_write_en`=0. Release; stays idle with `req`=0.
- LW at `addr`=0x28, mem[10]=5 → cycle 1: `mem_adr`=10, `mem_write_en`=0. Cycle 2: `done`=1, `rdata`=5, `err`=0.
- SB `wdata`=0x000000AB at `addr`=0x2D, mem[11]=8 → mem[11]=0x0000AB08. Then LBU at 0x2D → `rdata`=0xAB. Then LB at 0x2D → `rdata`=0xFFFFFFAB.
- Split LW at `addr`=0x2E, with mem[11]=0x0000AB08 and mem[12]=0x17:
  - `ready` low for cycles 1-2.
  - `mem_adr`=11, then 12.
  - Cycle 3: `done`=1, `rdata`=0x00170000.
- Wrap: SH `wdata`=0x1234 at `addr`=0x3FF → mem[255] lane 3=0x34, mem[0] lane 0=0x12, other lanes unchanged. Then funct3=011 load → `done`=1 and `err`=1 in the next cycle, with no memory write.
- Split SW at `addr`=0x3E, `wdata`=0xDEADBEEF; assert `rst_n`=0 during HI:
  - Result: mem[15] lanes 2-3 = 0xEF, 0xBE (0xEF in lane 2, 0xBE in lane 3); mem[16] unchanged.
  - During reset: `ready`=1, `mem_write_en`=0.
  - No `done` pulse.
